// File: rtl/edge_evt_pkg.sv
// Shared types for the edge-event scheduler.
// Edge modes and arbiter FSM states.
package edge_evt_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic [0:0] {
    EVT_IDLE    = 1'b0,
    EVT_PRESENT = 1'b1
  } evt_fsm_e;

endpackage

// File: rtl/edge_evt_arb_ch.sv
// One channel: synchroniser, edge history, qualified hit
// and pending / overflow bookkeeping.
module edge_evt_ch
  import edge_evt_pkg::*;
#(
  parameter int STAGE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dat,
  input  logic [1:0] mode,
  input  logic       acc,
  input  logic       pres,
  input  logic       ovf_clr,
  output logic       pend,
  output logic       ptype,
  output logic       ovf
);

  logic [STAGE-1:0] sync;
  logic             s_d;
  logic             s_q;
  logic             re;
  logic             fe;
  logic             hit;
  edge_mode_e       md;

  assign md  = edge_mode_e'(mode);
  assign s_d = sync[STAGE-1];
  assign re  = ~s_q & s_d;
  assign fe  = s_q & ~s_d;
  assign hit = (re & mode[0]) | (fe & mode[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      s_q   <= 1'b0;
      pend  <= 1'b0;
      ptype <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      sync <= {sync[STAGE-2:0], dat};
      s_q  <= s_d;
      // An edge landing on the accepted slot re-arms it.
      if (acc) begin
        pend <= hit;
        if (hit) ptype <= re;
      end else if (hit) begin
        if (!pend) begin
          pend  <= 1'b1;
          ptype <= re;
        end
      end else if (md == EDGE_OFF && !pres) begin
        pend <= 1'b0;
      end
      if (hit && pend && !acc) ovf <= 1'b1;
      else if (ovf_clr)        ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_evt_arb.sv
// Edge-event scheduler: per-channel edge latches served
// by a round-robin arbiter onto one valid/ready port.
module edge_evt_arb
  import edge_evt_pkg::*;
#(
  parameter int STAGE    = 2,
  parameter int CH_NUM   = 4,
  parameter int ID_WIDTH = $clog2(CH_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CH_NUM-1:0]     dat_i,
  input  logic [2*CH_NUM-1:0]   mode_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [ID_WIDTH-1:0]   evt_id_o,
  output logic                  evt_rise_o,
  output logic [CH_NUM-1:0]     pend_o,
  output logic [CH_NUM-1:0]     ovf_o,
  input  logic [CH_NUM-1:0]     ovf_clr_i
);

  evt_fsm_e            state;
  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] sel;
  logic                found;
  int                  idx;
  logic [CH_NUM-1:0]   ptype;
  logic [CH_NUM-1:0]   acc;
  logic [CH_NUM-1:0]   pres;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    assign pres[k] = evt_valid_o
                   & (evt_id_o == ID_WIDTH'(k));
    assign acc[k]  = pres[k] & evt_ready_i;

    edge_evt_ch #(
      .STAGE(STAGE)
    ) u_ch (
      .clk    (clk_i),
      .rst    (rst_i),
      .dat    (dat_i[k]),
      .mode   (mode_i[2*k +: 2]),
      .acc    (acc[k]),
      .pres   (pres[k]),
      .ovf_clr(ovf_clr_i[k]),
      .pend   (pend_o[k]),
      .ptype  (ptype[k]),
      .ovf    (ovf_o[k])
    );
  end

  // Search starts just after the last winner and wraps.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = (int'(ptr) + i) % CH_NUM;
      if (!found && pend_o[idx]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= EVT_IDLE;
      ptr         <= ID_WIDTH'(CH_NUM - 1);
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      evt_rise_o  <= 1'b0;
    end else begin
      unique case (state)
        EVT_IDLE: begin
          if (found) begin
            evt_valid_o <= 1'b1;
            evt_id_o    <= sel;
            evt_rise_o  <= ptype[sel];
            ptr         <= sel;
            state       <= EVT_PRESENT;
          end
        end
        EVT_PRESENT: begin
          if (evt_ready_i) begin
            evt_valid_o <= 1'b0;
            state       <= EVT_IDLE;
          end
        end
        default: state <= EVT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_evt_arb.sv
// Bench for edge_evt_arb: vector table, directed corner
// sequences and random traffic against a reference model.
module tb_edge_evt_arb;

  localparam int STAGE  = 2;
  localparam int CH_NUM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dat = '0;
  logic [7:0] mode = '0;
  logic       ready = 1'b0;
  logic [3:0] clr = '0;
  logic       evt_valid_o;
  logic [1:0] evt_id_o;
  logic       evt_rise_o;
  logic [3:0] pend_o;
  logic [3:0] ovf_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  edge_evt_arb #(
    .STAGE (STAGE),
    .CH_NUM(CH_NUM)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .dat_i      (dat),
    .mode_i     (mode),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(ready),
    .evt_id_o   (evt_id_o),
    .evt_rise_o (evt_rise_o),
    .pend_o     (pend_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (clr)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: the level seen STAGE edges ago versus
  // STAGE+1 edges ago gives the edge; pending/overflow and
  // rotating-priority selection follow the written rules.
  logic [3:0] samp [0:STAGE];
  logic [3:0] m_pend = '0;
  logic [3:0] m_type = '0;
  logic [3:0] m_ovf  = '0;
  logic       m_valid = 1'b0;
  logic       m_rise  = 1'b0;
  int         m_id    = 0;
  int         m_last  = CH_NUM - 1;

  always @(posedge clk) begin : model
    logic [3:0] nd, nq, np, nt, no;
    logic r, f, h, a, nv, nr;
    int best, d, bd, nid, nl;
    if (rst) begin
      for (int j = 0; j <= STAGE; j++) samp[j] <= '0;
      m_pend  <= '0;
      m_type  <= '0;
      m_ovf   <= '0;
      m_valid <= 1'b0;
      m_rise  <= 1'b0;
      m_id    <= 0;
      m_last  <= CH_NUM - 1;
    end else begin
      nd = samp[STAGE-1];
      nq = samp[STAGE];
      np = m_pend;
      nt = m_type;
      no = '0;
      for (int k = 0; k < CH_NUM; k++) begin
        r = nd[k] & ~nq[k];
        f = nq[k] & ~nd[k];
        h = (r & mode[2*k]) | (f & mode[2*k+1]);
        a = m_valid & ready & (m_id == k);
        no[k] = (h & m_pend[k] & ~a)
              | (m_ovf[k] & ~clr[k]);
        if (a) begin
          np[k] = h;
          if (h) nt[k] = r;
        end else if (h) begin
          if (!m_pend[k]) begin
            np[k] = 1'b1;
            nt[k] = r;
          end
        end else if (mode[2*k +: 2] == 2'b00
                     && !(m_valid && m_id == k)) begin
          np[k] = 1'b0;
        end
      end
      nv = m_valid; nid = m_id; nr = m_rise; nl = m_last;
      if (!m_valid) begin
        best = -1;
        bd   = CH_NUM;
        for (int k = 0; k < CH_NUM; k++) begin
          if (m_pend[k]) begin
            d = (k - m_last - 1 + 2*CH_NUM) % CH_NUM;
            if (d < bd) begin
              bd   = d;
              best = k;
            end
          end
        end
        if (best >= 0) begin
          nv  = 1'b1;
          nid = best;
          nr  = m_type[best];
          nl  = best;
        end
      end else if (ready) begin
        nv = 1'b0;
      end
      m_pend  <= np;
      m_type  <= nt;
      m_ovf   <= no;
      m_valid <= nv;
      m_id    <= nid;
      m_rise  <= nr;
      m_last  <= nl;
      for (int j = STAGE; j > 0; j--) samp[j] <= samp[j-1];
      samp[0] <= dat;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mdl_valid", 32'(evt_valid_o), 32'(m_valid));
      chk("mdl_pend", 32'(pend_o), 32'(m_pend));
      chk("mdl_ovf", 32'(ovf_o), 32'(m_ovf));
      if (m_valid) begin
        chk("mdl_id", 32'(evt_id_o), 32'(m_id));
        chk("mdl_rise", 32'(evt_rise_o), 32'(m_rise));
      end
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] dat;
    logic [7:0] mode;
    logic       ready;
    logic [3:0] clr;
    logic       valid;
    logic [1:0] id;
    logic       rise;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic r, input logic [3:0] d,
    input logic [7:0] m, input logic rd,
    input logic [3:0] c, input logic ev,
    input logic [1:0] ei, input logic er,
    input logic [3:0] ep, input logic [3:0] eo);
    vec_t t;
    t.rst = r; t.dat = d; t.mode = m;
    t.ready = rd; t.clr = c; t.valid = ev;
    t.id = ei; t.rise = er; t.pend = ep; t.ovf = eo;
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1; dat = '0; mode = '0;
    ready = 1'b0; clr = '0;
    tick();
    tick();
    chk("rst_valid", 32'(evt_valid_o), 32'd0);
    chk("rst_id", 32'(evt_id_o), 32'd0);
    chk("rst_rise", 32'(evt_rise_o), 32'd0);
    chk("rst_pend", 32'(pend_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int lim,
                            input string nm);
    int i;
    i = 0;
    while (!evt_valid_o && i < lim) begin
      tick();
      i++;
    end
    chk({nm, "_wait"}, 32'(evt_valid_o), 32'd1);
  endtask

  task automatic collect(input logic rise,
                         input string nm);
    int cnt, last;
    cnt  = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && cnt < CH_NUM; cyc++) begin
      tick();
      if (evt_valid_o) begin
        chk({nm, "_id"}, 32'(evt_id_o), 32'(cnt));
        chk({nm, "_rise"}, 32'(evt_rise_o), 32'(rise));
        if (cnt > 0)
          chk({nm, "_gap"}, 32'(cyc - last), 32'd2);
        last = cyc;
        cnt++;
      end
    end
    chk({nm, "_count"}, 32'(cnt), 32'(CH_NUM));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick();
    do_reset();
    chk_on = 1'b1;

    // ch0 rise-only: pend at edge 3, event at 4, ack at 7
    tbl.push_back(v(1, 4'h0, 8'h00, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h1, 8'h01, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h1, 8'h01, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h1, 8'h01, 0, 4'h0, 0, 0, 0, 4'h1, 4'h0));
    tbl.push_back(v(0, 4'h1, 8'h01, 0, 4'h0, 1, 0, 1, 4'h1, 4'h0));
    tbl.push_back(v(0, 4'h1, 8'h01, 0, 4'h0, 1, 0, 1, 4'h1, 4'h0));
    tbl.push_back(v(0, 4'h1, 8'h01, 0, 4'h0, 1, 0, 1, 4'h1, 4'h0));
    tbl.push_back(v(0, 4'h1, 8'h01, 1, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h1, 8'h01, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h0, 8'h01, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h0, 8'h01, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h0, 8'h01, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h0, 8'h01, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h0, 8'hFF, 0, 4'hF, 0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(v(0, 4'h0, 8'hFF, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; dat = tbl[i].dat;
      mode = tbl[i].mode; ready = tbl[i].ready;
      clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_valid", i),
          32'(evt_valid_o), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_pend", i),
          32'(pend_o), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_ovf", i),
          32'(ovf_o), 32'(tbl[i].ovf));
      if (tbl[i].valid || tbl[i].rst) begin
        chk($sformatf("tbl%0d_id", i),
            32'(evt_id_o), 32'(tbl[i].id));
        chk($sformatf("tbl%0d_rise", i),
            32'(evt_rise_o), 32'(tbl[i].rise));
      end
    end
    rst = 1'b0; clr = '0; ready = 1'b0;

    // all channels both edges, ready held high
    do_reset();
    mode = 8'hFF; ready = 1'b1; dat = 4'hF;
    collect(1'b1, "thr_up");
    dat = 4'h0;
    collect(1'b0, "thr_dn");
    ready = 1'b0;

    // overflow on ch2 while its first edge waits
    do_reset();
    mode = 8'h10;
    dat = 4'h4; tick(); tick();
    dat = 4'h0; repeat (4) tick();
    dat = 4'h4; tick(); tick();
    dat = 4'h0; repeat (4) tick();
    chk("ovf_set", 32'(ovf_o), 32'h4);
    chk("ovf_pend", 32'(pend_o), 32'h4);
    chk("ovf_id", 32'(evt_id_o), 32'd2);
    chk("ovf_rise", 32'(evt_rise_o), 32'd1);
    clr = 4'h4; tick(); clr = '0;
    chk("ovf_clr", 32'(ovf_o), 32'h0);
    tick();
    chk("ovf_clr_pend", 32'(pend_o), 32'h4);
    chk("ovf_clr_valid", 32'(evt_valid_o), 32'd1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("ovf_ack_valid", 32'(evt_valid_o), 32'd0);
    repeat (6) tick();
    chk("ovf_no_new", 32'(evt_valid_o), 32'd0);
    chk("ovf_no_pend", 32'(pend_o), 32'h0);

    // ch1 fall-only
    do_reset();
    mode = 8'h08;
    dat = 4'h2; repeat (6) tick();
    chk("fall_rise_pend", 32'(pend_o), 32'h0);
    chk("fall_rise_valid", 32'(evt_valid_o), 32'd0);
    dat = 4'h0;
    wait_valid(10, "fall");
    chk("fall_id", 32'(evt_id_o), 32'd1);
    chk("fall_rise", 32'(evt_rise_o), 32'd0);
    ready = 1'b1; tick(); ready = 1'b0;

    // switching off a pending, not presented channel
    do_reset();
    mode = 8'h41; dat = 4'h9;
    wait_valid(10, "off_np");
    chk("off_np_id", 32'(evt_id_o), 32'd0);
    tick();
    chk("off_np_pend0", 32'(pend_o), 32'h9);
    mode = 8'h01; tick();
    chk("off_np_pend1", 32'(pend_o), 32'h1);
    chk("off_np_valid", 32'(evt_valid_o), 32'd1);
    ready = 1'b1; tick(); ready = 1'b0;
    repeat (5) tick();
    chk("off_np_none", 32'(evt_valid_o), 32'd0);
    chk("off_np_empty", 32'(pend_o), 32'h0);

    // switching off the presented channel
    do_reset();
    mode = 8'h01; dat = 4'h1;
    wait_valid(10, "off_p");
    mode = 8'h00;
    repeat (3) begin
      tick();
      chk("off_p_valid", 32'(evt_valid_o), 32'd1);
      chk("off_p_pend", 32'(pend_o), 32'h1);
    end
    ready = 1'b1; tick(); ready = 1'b0;
    chk("off_p_ack", 32'(evt_valid_o), 32'd0);
    chk("off_p_clear", 32'(pend_o), 32'h0);

    // reset in the middle of a presentation
    do_reset();
    mode = 8'h55; dat = 4'hF;
    wait_valid(10, "mid");
    chk("mid_pend", 32'(pend_o), 32'hF);
    rst = 1'b1; dat = 4'h0; tick(); rst = 1'b0;
    chk("mid_valid", 32'(evt_valid_o), 32'd0);
    chk("mid_id", 32'(evt_id_o), 32'd0);
    chk("mid_rise", 32'(evt_rise_o), 32'd0);
    chk("mid_pend0", 32'(pend_o), 32'h0);
    chk("mid_ovf", 32'(ovf_o), 32'h0);
    repeat (8) tick();
    chk("mid_quiet", 32'(evt_valid_o), 32'd0);
    dat = 4'h4;
    n = 0;
    do begin
      tick();
      n++;
    end while (!evt_valid_o && n < 12);
    chk("mid_latency", 32'(n), 32'(STAGE + 2));
    chk("mid_new_id", 32'(evt_id_o), 32'd2);
    ready = 1'b1; tick(); ready = 1'b0;

    // random traffic, model checks every cycle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        dat = dat ^ 4'($urandom);
      if ($urandom_range(0, 19) == 0)
        mode = 8'($urandom);
      ready = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 9) == 0)
          ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
